// File: rtl/ycc_pkg.sv
// Shared constants for the YCbCr -> RGB565 decode path: Q10 coefficients,
// accumulator sizing and RGB565 field layout.
package ycc_pkg;

  localparam int FRAC  = 10;
  localparam int ACC_W = 20;

  localparam logic signed [ACC_W-1:0] KRV = 20'sd1436;
  localparam logic signed [ACC_W-1:0] KGU = 20'sd352;
  localparam logic signed [ACC_W-1:0] KGV = 20'sd731;
  localparam logic signed [ACC_W-1:0] KBU = 20'sd1815;
  localparam logic signed [ACC_W-1:0] RND = 20'sd512;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  function automatic logic [15:0] pack565(input logic [7:0] r8,
                                          input logic [7:0] g8,
                                          input logic [7:0] b8);
    logic [15:0] p;
    p = '0;
    p[R_MSB:R_LSB] = r8[7:3];
    p[G_MSB:G_LSB] = g8[7:2];
    p[B_MSB:B_LSB] = b8[7:3];
    return p;
  endfunction

endpackage

// File: rtl/ycc_clamp8.sv
// Drops the Q10 fraction of a rounded accumulator and saturates to 0..255.
module ycc_clamp8
  import ycc_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic        [7:0]       pix
);

  function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    t = s >>> FRAC;
    if (t < 0)
      return 8'h00;
    else if (t > 255)
      return 8'hFF;
    else
      return t[7:0];
  endfunction

  assign pix = sat_u8(acc);

endmodule

// File: rtl/ycbcr_to_rgb565.sv
// Level-shifted signed YCbCr to RGB565, three-stage valid/ready pipeline with
// a global stall and an 8x8-block last-pixel marker.
module ycbcr_to_rgb565
  import ycc_pkg::*;
#(
  parameter int PIXELS_PER_BLOCK = 64
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [7:0]  In_Y,
  input  logic [7:0]  In_Cb,
  input  logic [7:0]  In_Cr,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Out_Data,
  output logic        Out_Last
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (PIXELS_PER_BLOCK > 1) ? $clog2(PIXELS_PER_BLOCK) : 1;

  logic                    advance;
  logic signed [ACC_W-1:0] y_ext, cb_ext, cr_ext;
  logic                    vld_p0, vld_p1, vld_p2;
  logic signed [ACC_W-1:0] y_p0, rv_p0, gu_p0, gv_p0, bu_p0;
  logic signed [ACC_W-1:0] sr_p1, sg_p1, sb_p1;
  logic        [7:0]       r8, g8, b8;
  logic        [15:0]      data_p2;
  logic        [CNT_W-1:0] cnt;
  logic                    last_hit;

  // The whole pipe moves as one: any empty output slot or a taking sink frees it.
  assign advance  = Out_Ready | ~vld_p2;
  assign In_Ready = advance;

  // Luma offset is removed by flipping the sign bit, then aligned to Q10.
  assign y_ext  = {{(ACC_W-DATA_W-FRAC){1'b0}}, ~In_Y[7], In_Y[6:0], {FRAC{1'b0}}};
  assign cb_ext = {{(ACC_W-DATA_W){In_Cb[7]}}, In_Cb};
  assign cr_ext = {{(ACC_W-DATA_W){In_Cr[7]}}, In_Cr};

  // Stage 1: constant products
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p0 <= 1'b0;
      y_p0   <= '0;
      rv_p0  <= '0;
      gu_p0  <= '0;
      gv_p0  <= '0;
      bu_p0  <= '0;
    end else if (advance) begin
      vld_p0 <= In_Valid;
      y_p0   <= y_ext;
      rv_p0  <= cr_ext * KRV;
      gu_p0  <= cb_ext * KGU;
      gv_p0  <= cr_ext * KGV;
      bu_p0  <= cb_ext * KBU;
    end
  end

  // Stage 2: rounded channel sums
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1 <= 1'b0;
      sr_p1  <= '0;
      sg_p1  <= '0;
      sb_p1  <= '0;
    end else if (advance) begin
      vld_p1 <= vld_p0;
      sr_p1  <= y_p0 + rv_p0 + RND;
      sg_p1  <= y_p0 - gu_p0 - gv_p0 + RND;
      sb_p1  <= y_p0 + bu_p0 + RND;
    end
  end

  ycc_clamp8 u_clamp_r (.acc(sr_p1), .pix(r8));
  ycc_clamp8 u_clamp_g (.acc(sg_p1), .pix(g8));
  ycc_clamp8 u_clamp_b (.acc(sb_p1), .pix(b8));

  // Stage 3: saturate and pack
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (advance) begin
      vld_p2  <= vld_p1;
      data_p2 <= pack565(r8, g8, b8);
    end
  end

  assign last_hit = (cnt == CNT_W'(PIXELS_PER_BLOCK - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      cnt <= '0;
    else if (vld_p2 && Out_Ready)
      cnt <= last_hit ? '0 : cnt + 1'b1;
  end

  assign Out_Valid = vld_p2;
  assign Out_Data  = data_p2;
  assign Out_Last  = vld_p2 & last_hit;

endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Randomised and directed bench for ycbcr_to_rgb565 against an integer colour model.
module tb_ycbcr_to_rgb565;

  localparam int PPB = 64;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  In_Y, In_Cb, In_Cr;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Data;
  logic        Out_Last;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  int          out_idx = 0;
  int          n_out   = 0;
  int          n_last  = 0;

  ycbcr_to_rgb565 #(.PIXELS_PER_BLOCK(PPB)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Y(In_Y), .In_Cb(In_Cb), .In_Cr(In_Cr),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Data(Out_Data), .Out_Last(Out_Last)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Floor division by 1024 for signed integers.
  function automatic int fdiv1024(input int n);
    int q;
    q = n / 1024;
    if ((n % 1024) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp255(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    int yu, u, v, r, g, b;
    logic [7:0] r8, g8, b8;
    yu = int'(y) - 128 + 128 * 2 * int'(y < 8'h80);
    yu = (y < 8'h80) ? int'(y) + 128 : int'(y) - 128;
    u  = int'($signed(cb));
    v  = int'($signed(cr));
    r  = clamp255(fdiv1024(yu * 1024 + 1436 * v + 512));
    g  = clamp255(fdiv1024(yu * 1024 - 352 * u - 731 * v + 512));
    b  = clamp255(fdiv1024(yu * 1024 + 1815 * u + 512));
    r8 = 8'(r);
    g8 = 8'(g);
    b8 = 8'(b);
    return {r8[7:3], g8[7:2], b8[7:3]};
  endfunction

  // Scoreboard: capture accepted inputs, check every output transfer and stall hold.
  initial begin : monitor
    logic        stall_prev;
    logic [15:0] held_d;
    logic        held_l;
    logic [15:0] e;
    stall_prev = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Reset_n) begin
        exp_q.delete();
        out_idx    = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_data", Out_Data, held_d);
          chk("hold_last", Out_Last, held_l);
        end
        if (In_Valid && In_Ready) exp_q.push_back(model(In_Y, In_Cb, In_Cr));
        if (Out_Valid && Out_Ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("data", Out_Data, e);
            chk("last", Out_Last, (out_idx % PPB) == PPB - 1);
            out_idx++;
            n_out++;
            if (Out_Last) n_last++;
          end
        end
        stall_prev = Out_Valid && !Out_Ready;
        held_d     = Out_Data;
        held_l     = Out_Last;
      end
    end
  end

  task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    int k;
    k = 0;
    In_Y = y; In_Cb = cb; In_Cr = cr; In_Valid = 1'b1;
    @(negedge Clock);
    while (!In_Ready && k < 50) begin
      @(negedge Clock);
      k++;
    end
    if (k >= 50) chk("send_timeout", k, 0);
    @(posedge Clock); #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    while ((exp_q.size() != 0 || Out_Valid) && k < 30) begin
      @(posedge Clock); #1;
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic one_px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic [15:0] exp, input string tag);
    int lat;
    In_Y = y; In_Cb = cb; In_Cr = cr; In_Valid = 1'b1;
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    lat = 1;
    while (!Out_Valid && lat < 10) begin
      @(posedge Clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk(tag, Out_Data, exp);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int base, lbase;
    logic [15:0] hd;
    logic hist[0:19];

    Reset_n = 1'b0; In_Valid = 1'b0; In_Y = '0; In_Cb = '0; In_Cr = '0; Out_Ready = 1'b1;
    #3;
    chk("rst_valid", Out_Valid, 0);
    chk("rst_data", Out_Data, 16'h0000);
    chk("rst_last", Out_Last, 0);
    @(posedge Clock); @(posedge Clock); #1 Reset_n = 1'b1;
    #1 chk("ready_after_rst", In_Ready, 1);

    one_px(8'h00, 8'h00, 8'h00, 16'h8410, "grey");
    one_px(8'h7F, 8'h00, 8'h00, 16'hFFFF, "white");
    one_px(8'h80, 8'h00, 8'h00, 16'h0000, "black");
    one_px(8'h7F, 8'h00, 8'h7F, 16'hFD3F, "sat_hi");
    one_px(8'h80, 8'h00, 8'h80, 16'h02C0, "sat_lo");
    chk("sat_lo_r", Out_Data[15:11], 0);
    drain();

    // Bubbles: alternate valid, output valid must echo it three cycles on.
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      if (i >= 3) chk("bubble", Out_Valid, hist[i-3]);
      In_Valid = (i % 2) == 0;
      In_Y = 8'($urandom); In_Cb = 8'($urandom); In_Cr = 8'($urandom);
      hist[i] = In_Valid;
    end
    drain();

    // Backpressure mid-stream.
    base = n_out;
    send(8'h10, 8'h05, 8'hF0);
    send(8'h20, 8'hE0, 8'h11);
    send(8'h30, 8'h40, 8'h40);
    Out_Ready = 1'b0;
    In_Y = 8'h40; In_Cb = 8'h81; In_Cr = 8'h7E; In_Valid = 1'b1;
    hd = Out_Data;
    chk("bp_out_valid", Out_Valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("bp_ready", In_Ready, 0);
      chk("bp_hold", Out_Data, hd);
      @(posedge Clock); #1;
    end
    Out_Ready = 1'b1;
    send(8'h40, 8'h81, 8'h7E);
    send(8'h50, 8'h22, 8'hC3);
    send(8'h60, 8'h9A, 8'h3C);
    drain();
    chk("bp_count", n_out - base, 6);

    // Block framing over 130 pixels from a clean counter.
    do_reset();
    base = n_out; lbase = n_last;
    for (int i = 0; i < 130; i++) send(8'($urandom), 8'($urandom), 8'($urandom));
    drain();
    chk("frame_count", n_out - base, 130);
    chk("frame_lasts", n_last - lbase, 2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge Clock); #1;
      In_Valid  = $urandom_range(0, 3) != 0;
      In_Y = 8'($urandom); In_Cb = 8'($urandom); In_Cr = 8'($urandom);
      Out_Ready = $urandom_range(0, 3) != 0;
    end
    drain();

    // Reset with pixels in flight.
    send(8'h11, 8'h22, 8'h33);
    send(8'h44, 8'h55, 8'h66);
    send(8'h77, 8'h88, 8'h99);
    chk("inflight_valid", Out_Valid, 1);
    Reset_n = 1'b0;
    #1 chk("async_rst_valid", Out_Valid, 0);
    chk("async_rst_last", Out_Last, 0);
    @(posedge Clock); #1 Reset_n = 1'b1;
    In_Valid = 1'b0;
    base = n_out; lbase = n_last;
    for (int i = 0; i < 64; i++) send(8'($urandom), 8'($urandom), 8'($urandom));
    drain();
    chk("post_rst_count", n_out - base, 64);
    chk("post_rst_lasts", n_last - lbase, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
